// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the SPI slave command sequencer:
//   - state_e   : sequencer phase encoding
//   - reg_sel_e : register-select encodings driven toward the register file
//   - CMD_BITS / REG_BITS : width of the command byte and register byte
//   - ADDR_INC  : byte stride between consecutive memory words
// ---------------------------------------------------------------------------
package spi_slave_pkg;

    localparam int CMD_BITS = 8;
    localparam int REG_BITS = 8;
    localparam int ADDR_INC = 4;

    typedef enum logic [2:0] {
        ST_CMD     = 3'd0,
        ST_ADDR    = 3'd1,
        ST_MODE    = 3'd2,
        ST_DUMMY   = 3'd3,
        ST_DATA_RX = 3'd4,
        ST_DATA_TX = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'b00,
        REG_DUMMY   = 2'b01,
        REG_WRAP_LO = 2'b10,
        REG_WRAP_HI = 2'b11
    } reg_sel_e;

endpackage

// File: rtl/spi_slave_dummy_cnt.sv
// ---------------------------------------------------------------------------
// spi_slave_dummy_cnt
// Loadable down-counter used to time the dummy phase of a transaction.
// Ports:
//   clk        : clock (SPI clock in the parent)
//   srst       : synchronous active-high reset
//   i_load     : load i_load_val this cycle
//   i_load_val : dummy clock count
//   o_done     : count has reached 1, i.e. this is the last dummy cycle
// The counter parks at 0 once exhausted.
// ---------------------------------------------------------------------------
module spi_slave_dummy_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == WIDTH'(1));

endmodule

// File: rtl/spi_slave_cmd_seq.sv
// ---------------------------------------------------------------------------
// spi_slave_cmd_seq
// Transaction sequencer of the SPI slave, clocked by sclk. It hands the first
// received byte to the external command decoder, consumes the decode fields
// and walks the transaction through ADDR / MODE / DUMMY / DATA phases, issuing
// register writes, memory-write words and memory-read requests.
//
// Ports:
//   sclk, sys_rst          : SPI clock, synchronous active-high reset
//   cs_active              : chip-select; low aborts to CMD
//   rx_data/rx_valid       : word from the RX shifter
//   rx_cnt/rx_cnt_upd      : next RX word length and its load strobe
//   cmd                    : command byte toward the decoder
//   get_addr..error,
//   reg_sel_in             : decoder fields
//   dummy_cycles           : dummy clock count from the register file
//   reg_wr/reg_sel/reg_wdata            : register write port
//   mem_wr_valid/mem_wdata/mem_addr     : memory write port / word address
//   mem_rd_req             : memory read request
//   tx_en/tx_cnt/tx_cnt_upd/tx_done     : TX shifter control
//
// Optional build macro SPI_SLAVE_ERR_CNT_EN adds err_cnt_clr / err_cnt, a
// saturating count of commands the decoder flagged as errors.
// ---------------------------------------------------------------------------
module spi_slave_cmd_seq
    import spi_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DUMMY_WIDTH = 8
) (
    input  logic                   sclk,
    input  logic                   sys_rst,
    input  logic                   cs_active,
    input  logic [DATA_WIDTH-1:0]  rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             rx_cnt,
    output logic                   rx_cnt_upd,
    output logic [7:0]             cmd,
    input  logic                   get_addr,
    input  logic                   get_mode,
    input  logic                   get_data,
    input  logic                   send_data,
    input  logic                   enable_cont,
    input  logic                   enable_regs,
    input  logic                   wait_dummy,
    input  logic                   error,
    input  logic [1:0]             reg_sel_in,
    input  logic [DUMMY_WIDTH-1:0] dummy_cycles,
    output logic                   reg_wr,
    output logic [1:0]             reg_sel,
    output logic [7:0]             reg_wdata,
    output logic                   mem_wr_valid,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_rd_req,
    output logic                   tx_en,
    output logic [7:0]             tx_cnt,
    output logic                   tx_cnt_upd,
    input  logic                   tx_done
`ifdef SPI_SLAVE_ERR_CNT_EN
    ,
    input  logic                   err_cnt_clr,
    output logic [7:0]             err_cnt
`endif
);

    state_e                  r_state;
    logic [CMD_BITS-1:0]     r_cmd;
    logic                    r_get_mode;
    logic                    r_wait;
    logic                    r_get;
    logic                    r_send;
    logic                    r_regs;
    logic                    r_cont;
    reg_sel_e                r_reg_sel;
    logic [7:0]              r_rx_cnt;
    logic                    r_rx_cnt_upd;
    logic                    r_reg_wr;
    logic [REG_BITS-1:0]     r_reg_wdata;
    logic                    r_mem_wr_valid;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    r_mem_rd_req;
    logic                    r_tx_en;
    logic [7:0]              r_tx_cnt;
    logic                    r_tx_cnt_upd;
    logic                    r_wr_inc;   // bump mem_addr the cycle after a write
    logic                    r_rd_pend;  // issue a read the cycle after the bump

    // In CMD the decoder fields are live inputs; afterwards the latched copies
    // describe the transaction.
    logic   w_in_cmd;
    logic   w_f_mode, w_f_wait, w_f_get, w_f_send, w_f_regs, w_f_cont;
    logic   w_dummy_zero;
    logic   w_dummy_done;
    logic   w_dummy_load;
    logic   w_go;
    state_e w_tgt;
    state_e w_data_tgt;
    state_e w_after_mode;
    state_e w_after_addr;

    assign w_in_cmd = (r_state == ST_CMD);
    assign w_f_mode = w_in_cmd ? get_mode    : r_get_mode;
    assign w_f_wait = w_in_cmd ? wait_dummy  : r_wait;
    assign w_f_get  = w_in_cmd ? get_data    : r_get;
    assign w_f_send = w_in_cmd ? send_data   : r_send;
    assign w_f_regs = w_in_cmd ? enable_regs : r_regs;
    assign w_f_cont = w_in_cmd ? enable_cont : r_cont;

    assign w_dummy_zero = (dummy_cycles == '0);
    assign w_data_tgt   = w_f_get ? ST_DATA_RX : (w_f_send ? ST_DATA_TX : ST_DONE);
    // A zero dummy count skips the DUMMY state altogether.
    assign w_after_mode = (w_f_wait && !w_dummy_zero) ? ST_DUMMY : w_data_tgt;
    assign w_after_addr = w_f_mode ? ST_MODE : w_after_mode;

    // Phase-exit decision; entry actions below key off the target state.
    always_comb begin
        w_go  = 1'b0;
        w_tgt = r_state;
        unique case (r_state)
            ST_CMD: begin
                if (rx_valid) begin
                    w_go = 1'b1;
                    if (error)         w_tgt = ST_DONE;
                    else if (get_addr) w_tgt = ST_ADDR;
                    else               w_tgt = w_after_addr;
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    w_go  = 1'b1;
                    w_tgt = w_after_addr;
                end
            end
            ST_MODE: begin
                if (rx_valid) begin
                    w_go  = 1'b1;
                    w_tgt = w_after_mode;
                end
            end
            ST_DUMMY: begin
                if (w_dummy_done) begin
                    w_go  = 1'b1;
                    w_tgt = w_data_tgt;
                end
            end
            ST_DATA_RX: begin
                // Streaming writes stay here until chip-select drops.
                if (rx_valid && (r_regs || !r_cont)) begin
                    w_go  = 1'b1;
                    w_tgt = ST_DONE;
                end
            end
            ST_DATA_TX: begin
                if (tx_done && !r_cont) begin
                    w_go  = 1'b1;
                    w_tgt = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    assign w_dummy_load = cs_active && w_go && (w_tgt == ST_DUMMY);

    spi_slave_dummy_cnt #(
        .WIDTH (DUMMY_WIDTH)
    ) u_dummy_cnt (
        .clk        (sclk),
        .srst       (sys_rst),
        .i_load     (w_dummy_load),
        .i_load_val (dummy_cycles),
        .o_done     (w_dummy_done)
    );

    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            r_state        <= ST_CMD;
            r_cmd          <= '0;
            r_get_mode     <= 1'b0;
            r_wait         <= 1'b0;
            r_get          <= 1'b0;
            r_send         <= 1'b0;
            r_regs         <= 1'b0;
            r_cont         <= 1'b0;
            r_reg_sel      <= REG_CTRL;
            r_rx_cnt       <= 8'(CMD_BITS);
            r_rx_cnt_upd   <= 1'b0;
            r_reg_wr       <= 1'b0;
            r_reg_wdata    <= '0;
            r_mem_wr_valid <= 1'b0;
            r_mem_wdata    <= '0;
            r_mem_addr     <= '0;
            r_mem_rd_req   <= 1'b0;
            r_tx_en        <= 1'b0;
            r_tx_cnt       <= '0;
            r_tx_cnt_upd   <= 1'b0;
            r_wr_inc       <= 1'b0;
            r_rd_pend      <= 1'b0;
        end else begin
            r_rx_cnt_upd   <= 1'b0;
            r_tx_cnt_upd   <= 1'b0;
            r_reg_wr       <= 1'b0;
            r_mem_wr_valid <= 1'b0;
            r_mem_rd_req   <= 1'b0;

            if (!cs_active) begin
                // Abort outranks everything else seen in this cycle.
                r_state      <= ST_CMD;
                r_rx_cnt     <= 8'(CMD_BITS);
                r_rx_cnt_upd <= 1'b1;
                r_tx_en      <= 1'b0;
                r_wr_inc     <= 1'b0;
                r_rd_pend    <= 1'b0;
            end else begin
                if (r_wr_inc) begin
                    r_mem_addr <= r_mem_addr + ADDR_WIDTH'(ADDR_INC);
                    r_wr_inc   <= 1'b0;
                end
                if (r_rd_pend) begin
                    r_mem_rd_req <= 1'b1;
                    r_tx_cnt_upd <= 1'b1;
                    r_rd_pend    <= 1'b0;
                end

                if (r_state == ST_CMD && rx_valid) begin
                    r_cmd      <= rx_data[CMD_BITS-1:0];
                    r_get_mode <= get_mode;
                    r_wait     <= wait_dummy;
                    r_get      <= get_data;
                    r_send     <= send_data;
                    r_regs     <= enable_regs;
                    r_cont     <= enable_cont;
                    r_reg_sel  <= reg_sel_e'(reg_sel_in);
                end

                if (r_state == ST_ADDR && rx_valid) begin
                    r_mem_addr <= rx_data[ADDR_WIDTH-1:0];
                end

                if (r_state == ST_DATA_RX && rx_valid) begin
                    if (r_regs) begin
                        r_reg_wr    <= 1'b1;
                        r_reg_wdata <= rx_data[REG_BITS-1:0];
                    end else begin
                        r_mem_wr_valid <= 1'b1;
                        r_mem_wdata    <= rx_data;
                        r_wr_inc       <= r_cont;
                    end
                end

                if (r_state == ST_DATA_TX && tx_done && r_cont) begin
                    r_mem_addr <= r_mem_addr + ADDR_WIDTH'(ADDR_INC);
                    r_rd_pend  <= 1'b1;
                end

                if (w_go) begin
                    r_state <= w_tgt;
                    unique case (w_tgt)
                        ST_ADDR: begin
                            r_rx_cnt     <= 8'(ADDR_WIDTH);
                            r_rx_cnt_upd <= 1'b1;
                        end
                        ST_MODE: begin
                            r_rx_cnt     <= 8'(CMD_BITS);
                            r_rx_cnt_upd <= 1'b1;
                        end
                        ST_DATA_RX: begin
                            r_rx_cnt     <= w_f_regs ? 8'(REG_BITS) : 8'(DATA_WIDTH);
                            r_rx_cnt_upd <= 1'b1;
                        end
                        ST_DATA_TX: begin
                            r_tx_en      <= 1'b1;
                            r_tx_cnt     <= w_f_regs ? 8'(REG_BITS) : 8'(DATA_WIDTH);
                            r_tx_cnt_upd <= 1'b1;
                            r_mem_rd_req <= w_f_cont;
                        end
                        ST_DONE: begin
                            r_tx_en <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // The decoder sees the live byte in CMD so its fields settle in the same
    // cycle as rx_valid; later phases see the latched command.
    assign cmd          = w_in_cmd ? rx_data[CMD_BITS-1:0] : r_cmd;
    assign rx_cnt       = r_rx_cnt;
    assign rx_cnt_upd   = r_rx_cnt_upd;
    assign reg_wr       = r_reg_wr;
    assign reg_sel      = r_reg_sel;
    assign reg_wdata    = r_reg_wdata;
    assign mem_wr_valid = r_mem_wr_valid;
    assign mem_wdata    = r_mem_wdata;
    assign mem_addr     = r_mem_addr;
    assign mem_rd_req   = r_mem_rd_req;
    assign tx_en        = r_tx_en;
    assign tx_cnt       = r_tx_cnt;
    assign tx_cnt_upd   = r_tx_cnt_upd;

`ifdef SPI_SLAVE_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge sclk) begin
        if (sys_rst) begin
            r_err_cnt <= '0;
        end else if (err_cnt_clr) begin
            r_err_cnt <= '0;
        end else if (cs_active && w_in_cmd && rx_valid && error && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_spi_slave_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_cmd_seq
// Bench for spi_slave_cmd_seq. A small decoder model maps the command byte
// to decode fields. Memory/register strobes are checked against a queue of
// expected events filled as stimulus is driven; a transaction table drives
// the main flows and hand-written sequences cover reset, abort and errors.
// ---------------------------------------------------------------------------
module tb_spi_slave_cmd_seq;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DMW = 8;
    localparam logic [1:0] K_REG = 2'd0;
    localparam logic [1:0] K_WR  = 2'd1;
    localparam logic [1:0] K_RD  = 2'd2;

    logic           sclk = 1'b0;
    logic           sys_rst;
    logic           cs_active;
    logic [DW-1:0]  rx_data;
    logic           rx_valid;
    logic [7:0]     rx_cnt;
    logic           rx_cnt_upd;
    logic [7:0]     cmd;
    logic           get_addr, get_mode, get_data, send_data;
    logic           enable_cont, enable_regs, wait_dummy, error;
    logic [1:0]     reg_sel_in;
    logic [DMW-1:0] dummy_cycles;
    logic           reg_wr;
    logic [1:0]     reg_sel;
    logic [7:0]     reg_wdata;
    logic           mem_wr_valid;
    logic [DW-1:0]  mem_wdata;
    logic [AW-1:0]  mem_addr;
    logic           mem_rd_req;
    logic           tx_en;
    logic [7:0]     tx_cnt;
    logic           tx_cnt_upd;
    logic           tx_done;
`ifdef SPI_SLAVE_ERR_CNT_EN
    logic           err_cnt_clr;
    logic [7:0]     err_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sclk = ~sclk;

    spi_slave_cmd_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DUMMY_WIDTH(DMW)) dut (
        .sclk(sclk), .sys_rst(sys_rst), .cs_active(cs_active),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_cnt(rx_cnt), .rx_cnt_upd(rx_cnt_upd),
        .cmd(cmd), .get_addr(get_addr), .get_mode(get_mode), .get_data(get_data),
        .send_data(send_data), .enable_cont(enable_cont), .enable_regs(enable_regs),
        .wait_dummy(wait_dummy), .error(error), .reg_sel_in(reg_sel_in),
        .dummy_cycles(dummy_cycles), .reg_wr(reg_wr), .reg_sel(reg_sel),
        .reg_wdata(reg_wdata), .mem_wr_valid(mem_wr_valid), .mem_wdata(mem_wdata),
        .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .tx_en(tx_en), .tx_cnt(tx_cnt),
        .tx_cnt_upd(tx_cnt_upd), .tx_done(tx_done)
`ifdef SPI_SLAVE_ERR_CNT_EN
        , .err_cnt_clr(err_cnt_clr), .err_cnt(err_cnt)
`endif
    );

    // Decoder model
    always_comb begin
        get_addr = 1'b0; get_mode = 1'b0; get_data = 1'b0; send_data = 1'b0;
        enable_cont = 1'b0; enable_regs = 1'b0; wait_dummy = 1'b0; error = 1'b0;
        reg_sel_in = 2'b00;
        case (cmd)
            8'h01: begin get_data = 1'b1; enable_regs = 1'b1; end
            8'h11: begin get_data = 1'b1; enable_regs = 1'b1; reg_sel_in = 2'b01; end
            8'h02: begin get_addr = 1'b1; get_data = 1'b1; enable_cont = 1'b1; end
            8'h03: begin get_addr = 1'b1; send_data = 1'b1; enable_cont = 1'b1; end
            8'h0B: begin get_addr = 1'b1; wait_dummy = 1'b1; send_data = 1'b1; enable_cont = 1'b1; end
            8'h05: begin send_data = 1'b1; enable_regs = 1'b1; end
            8'h0D: begin get_addr = 1'b1; get_mode = 1'b1; get_data = 1'b1; enable_cont = 1'b1; end
            default: error = 1'b1;
        endcase
    end

    // Scoreboard
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  sel;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] sel);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.sel = sel;
        exp_q.push_back(e);
    endtask

    task automatic got_event(input logic [1:0] kind, input logic [31:0] addr,
                             input logic [31:0] data, input logic [1:0] sel);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_strobe: kind %0d addr 0x%08h data 0x%08h, expected none",
                     kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 64'(kind), 64'(e.kind));
            if (e.kind != K_REG) check("ev_addr", 64'(addr), 64'(e.addr));
            if (e.kind != K_RD)  check("ev_data", 64'(data), 64'(e.data));
            if (e.kind == K_REG) check("ev_reg_sel", 64'(sel), 64'(e.sel));
        end
    endtask

    always @(negedge sclk) begin
        if (!sys_rst) begin
            if (reg_wr)       got_event(K_REG, 32'h0, {24'h0, reg_wdata}, reg_sel);
            if (mem_wr_valid) got_event(K_WR, mem_addr, mem_wdata, 2'b00);
            if (mem_rd_req)   got_event(K_RD, mem_addr, 32'h0, 2'b00);
        end
    end

    // Drivers
    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic rx_pulse(input logic [31:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic tx_pulse();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic cs_drop();
        cs_active = 1'b0;
        tick();
        cs_active = 1'b1;
    endtask

    task automatic wait_tx_en(output int lat);
        lat = 0;
        while (tx_en !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rx_cnt"},    64'(rx_cnt), 64'd8);
        check({tag, "_tx_en"},     64'(tx_en), 64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr), 64'd0);
        check({tag, "_strobes"},   64'({reg_wr, mem_wr_valid, mem_rd_req, rx_cnt_upd, tx_cnt_upd}), 64'd0);
        check({tag, "_reg_sel"},   64'(reg_sel), 64'd0);
        check({tag, "_wdata"},     64'({reg_wdata, mem_wdata}), 64'd0);
        rx_data = 32'h0000_005A;
        #1;
        check({tag, "_cmd_live"},  64'(cmd), 64'h5A);
    endtask

    // Transaction table
    typedef struct {
        logic [7:0]  cmd;
        bit          has_addr;
        bit          has_mode;
        logic [31:0] addr;
        logic [7:0]  dummy;
        int          n_rx;
        logic [31:0] d0;
        logic [31:0] d1;
        int          n_tx;
        bit          regs;
        logic [1:0]  sel;
        logic [7:0]  exp_rx_cnt;
        int          exp_lat;
        logic [7:0]  exp_tx_cnt;
    } vec_t;
    vec_t tbl[8];

    task automatic run_txn(input int idx, input vec_t v);
        int lat;
        logic [31:0] a;
        $display("txn %0d: cmd 0x%02h addr 0x%08h dummy %0d rx %0d tx %0d",
                 idx, v.cmd, v.addr, v.dummy, v.n_rx, v.n_tx);
        dummy_cycles = v.dummy;
        if (v.n_tx > 0 && !v.regs) begin
            a = v.addr;
            for (int i = 0; i < v.n_tx; i++) begin
                push_ev(K_RD, a, 32'h0, 2'b00);
                a = a + 32'd4;
            end
        end
        rx_pulse({24'h0, v.cmd});
        if (v.has_addr) begin
            check("rx_cnt_addr", 64'(rx_cnt), 64'd32);
            rx_pulse(v.addr);
        end
        if (v.has_mode) begin
            check("rx_cnt_mode", 64'(rx_cnt), 64'd8);
            rx_pulse(32'h0000_00A0);
        end
        if (v.n_rx > 0) begin
            check("rx_cnt_data", 64'(rx_cnt), 64'(v.exp_rx_cnt));
            for (int i = 0; i < v.n_rx; i++) begin
                if (v.regs) push_ev(K_REG, 32'h0, {24'h0, v.d0[7:0]}, v.sel);
                else        push_ev(K_WR, v.addr + 32'(4 * i), (i == 0) ? v.d0 : v.d1, 2'b00);
                rx_pulse((i == 0) ? v.d0 : v.d1);
                tick();
            end
            if (v.regs) begin
                rx_pulse(32'h0000_00EE);   // DONE must ignore this
                tick();
            end
        end
        if (v.n_tx > 0) begin
            wait_tx_en(lat);
            check("tx_latency", 64'(lat), 64'(v.exp_lat));
            check("tx_cnt", 64'(tx_cnt), 64'(v.exp_tx_cnt));
            check("tx_cnt_upd", 64'(tx_cnt_upd), 64'd1);
            if (v.regs) begin
                tick();
                tx_pulse();
                tick();
                check("tx_en_after_regs", 64'(tx_en), 64'd0);
            end else begin
                for (int i = 1; i < v.n_tx; i++) begin
                    tick();
                    tx_pulse();
                    tick();
                    tick();
                end
            end
        end
        rx_data = 32'h0000_00C3;
        #1;
        check("cmd_latched", 64'(cmd), 64'(v.cmd));
        cs_drop();
        check("cs_rx_cnt", 64'(rx_cnt), 64'd8);
        check("cs_rx_cnt_upd", 64'(rx_cnt_upd), 64'd1);
        check("cs_tx_en", 64'(tx_en), 64'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{cmd:8'h01, has_addr:0, has_mode:0, addr:32'h0, dummy:8'd0, n_rx:1,
                   d0:32'h1234_56A5, d1:32'h0, n_tx:0, regs:1, sel:2'b00,
                   exp_rx_cnt:8'd8, exp_lat:0, exp_tx_cnt:8'd0};
        tbl[1] = '{cmd:8'h11, has_addr:0, has_mode:0, addr:32'h0, dummy:8'd0, n_rx:1,
                   d0:32'h0000_003C, d1:32'h0, n_tx:0, regs:1, sel:2'b01,
                   exp_rx_cnt:8'd8, exp_lat:0, exp_tx_cnt:8'd0};
        tbl[2] = '{cmd:8'h02, has_addr:1, has_mode:0, addr:32'h0000_1000, dummy:8'd0, n_rx:2,
                   d0:32'h1111_1111, d1:32'h2222_2222, n_tx:0, regs:0, sel:2'b00,
                   exp_rx_cnt:8'd32, exp_lat:0, exp_tx_cnt:8'd0};
        tbl[3] = '{cmd:8'h0B, has_addr:1, has_mode:0, addr:32'hFFFF_FFFC, dummy:8'd4, n_rx:0,
                   d0:32'h0, d1:32'h0, n_tx:2, regs:0, sel:2'b00,
                   exp_rx_cnt:8'd0, exp_lat:4, exp_tx_cnt:8'd32};
        tbl[4] = '{cmd:8'h0B, has_addr:1, has_mode:0, addr:32'h0000_0200, dummy:8'd0, n_rx:0,
                   d0:32'h0, d1:32'h0, n_tx:1, regs:0, sel:2'b00,
                   exp_rx_cnt:8'd0, exp_lat:0, exp_tx_cnt:8'd32};
        tbl[5] = '{cmd:8'h0B, has_addr:1, has_mode:0, addr:32'h0000_0010, dummy:8'd1, n_rx:0,
                   d0:32'h0, d1:32'h0, n_tx:2, regs:0, sel:2'b00,
                   exp_rx_cnt:8'd0, exp_lat:1, exp_tx_cnt:8'd32};
        tbl[6] = '{cmd:8'h05, has_addr:0, has_mode:0, addr:32'h0, dummy:8'd0, n_rx:0,
                   d0:32'h0, d1:32'h0, n_tx:1, regs:1, sel:2'b00,
                   exp_rx_cnt:8'd0, exp_lat:0, exp_tx_cnt:8'd8};
        tbl[7] = '{cmd:8'h0D, has_addr:1, has_mode:1, addr:32'h0000_0080, dummy:8'd0, n_rx:1,
                   d0:32'hDEAD_BEEF, d1:32'h0, n_tx:0, regs:0, sel:2'b00,
                   exp_rx_cnt:8'd32, exp_lat:0, exp_tx_cnt:8'd0};

        sys_rst = 1'b1; cs_active = 1'b1; rx_data = '0; rx_valid = 1'b0;
        tx_done = 1'b0; dummy_cycles = '0;
`ifdef SPI_SLAVE_ERR_CNT_EN
        err_cnt_clr = 1'b0;
`endif
        repeat (3) tick();
        sys_rst = 1'b0;
        check_reset_state("reset");
        tick();

        // Reset while a read is in progress
        dummy_cycles = 8'd0;
        push_ev(K_RD, 32'h0000_3000, 32'h0, 2'b00);
        rx_pulse(32'h0000_0003);
        rx_pulse(32'h0000_3000);
        check("mid_tx_en", 64'(tx_en), 64'd1);
        tick();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        check_reset_state("midtx_rst");
        tick();
        tick();

        for (int i = 0; i < 8; i++) run_txn(i, tbl[i]);

        // Error command parks in DONE
        rx_pulse(32'h0000_00FF);
        rx_data = 32'h0000_0001;
        #1;
        check("err_cmd_held", 64'(cmd), 64'hFF);
        rx_pulse(32'h0000_0001);
        tick();
`ifdef SPI_SLAVE_ERR_CNT_EN
        check("err_cnt_one", 64'(err_cnt), 64'd1);
`endif
        cs_drop();
        rx_data = 32'h0000_0042;
        #1;
        check("err_back_to_cmd", 64'(cmd), 64'h42);
        tick();
`ifdef SPI_SLAVE_ERR_CNT_EN
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        check("err_cnt_clr", 64'(err_cnt), 64'd0);
        for (int i = 0; i < 256; i++) begin
            rx_pulse(32'h0000_00FF);
            cs_drop();
        end
        check("err_cnt_sat", 64'(err_cnt), 64'd255);
        rx_data = 32'h0000_00FF;
        rx_valid = 1'b1;
        err_cnt_clr = 1'b1;
        tick();
        rx_valid = 1'b0;
        err_cnt_clr = 1'b0;
        check("err_cnt_clr_wins", 64'(err_cnt), 64'd0);
        cs_drop();
`endif

        // Abort in DATA_RX coinciding with rx_valid: no write
        rx_pulse(32'h0000_0002);
        rx_pulse(32'h0000_2000);
        check("abort_rx_cnt_data", 64'(rx_cnt), 64'd32);
        cs_active = 1'b0;
        rx_data = 32'h9999_9999;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        cs_active = 1'b1;
        tick();
        tick();
        check("abort_rx_cnt", 64'(rx_cnt), 64'd8);
        rx_data = 32'h0000_0024;
        #1;
        check("abort_cmd_live", 64'(cmd), 64'h24);

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
